// File: rtl/id_exe_pipe_pkg.sv
// Shared definitions for the ID/EXE pipeline register and load-use interlock.
package id_exe_pipe_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned CTRL_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LU   = 2'd1,
        ST_HOLD = 2'd2
    } pipe_state_e;

    // Decoded payload carried from ID into EXE (control bundle width is per-instance).
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd_idx;
        logic            rd_wr_en;
        logic            mem_read;
    } exe_payload_t;

endpackage

// File: rtl/id_exe_pipe_if.sv
// Decode-to-EXE bus: decode-side payload and hazard flags in, EXE register and interlock status out.
interface id_exe_pipe_if
    import id_exe_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) ();

    logic              ID_valid_i;
    logic [XLEN-1:0]   ID_pc_i;
    logic [XLEN-1:0]   ID_rs1_data_i;
    logic [XLEN-1:0]   ID_rs2_data_i;
    logic              ID_rs1_luh_i;
    logic              ID_rs2_luh_i;
    logic [XLEN-1:0]   ID_imm_i;
    logic [4:0]        ID_rd_idx_i;
    logic              ID_rd_wr_en_i;
    logic              ID_mem_read_i;
    logic [CTRL_W-1:0] ID_ctrl_i;
    logic              EXE_stall_i;
    logic              flush_i;

    logic              EXE_valid_o;
    logic [XLEN-1:0]   EXE_pc_o;
    logic [XLEN-1:0]   EXE_rs1_data_o;
    logic [XLEN-1:0]   EXE_rs2_data_o;
    logic [XLEN-1:0]   EXE_imm_o;
    logic [4:0]        EXE_rd_idx_o;
    logic              EXE_rd_wr_en_o;
    logic              EXE_mem_read_o;
    logic [CTRL_W-1:0] EXE_ctrl_o;
    logic              ID_stall_o;
    logic              bypass_bubble_o;
    logic              bypass_stall_o;
    logic [CNT_W-1:0]  lu_bubble_cnt_o;
    logic [CNT_W-1:0]  stall_cycle_cnt_o;

    modport master (
        output ID_valid_i, ID_pc_i, ID_rs1_data_i, ID_rs2_data_i, ID_rs1_luh_i,
               ID_rs2_luh_i, ID_imm_i, ID_rd_idx_i, ID_rd_wr_en_i, ID_mem_read_i,
               ID_ctrl_i, EXE_stall_i, flush_i,
        input  EXE_valid_o, EXE_pc_o, EXE_rs1_data_o, EXE_rs2_data_o, EXE_imm_o,
               EXE_rd_idx_o, EXE_rd_wr_en_o, EXE_mem_read_o, EXE_ctrl_o,
               ID_stall_o, bypass_bubble_o, bypass_stall_o,
               lu_bubble_cnt_o, stall_cycle_cnt_o
    );

    modport slave (
        input  ID_valid_i, ID_pc_i, ID_rs1_data_i, ID_rs2_data_i, ID_rs1_luh_i,
               ID_rs2_luh_i, ID_imm_i, ID_rd_idx_i, ID_rd_wr_en_i, ID_mem_read_i,
               ID_ctrl_i, EXE_stall_i, flush_i,
        output EXE_valid_o, EXE_pc_o, EXE_rs1_data_o, EXE_rs2_data_o, EXE_imm_o,
               EXE_rd_idx_o, EXE_rd_wr_en_o, EXE_mem_read_o, EXE_ctrl_o,
               ID_stall_o, bypass_bubble_o, bypass_stall_o,
               lu_bubble_cnt_o, stall_cycle_cnt_o
    );

endinterface

// File: rtl/id_exe_pipe_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/id_exe_pipe.sv
// ID/EXE pipeline register with load-use bubble insertion, bypass-unit
// bubble/stall indications and saturating interlock counters.
module id_exe_pipe
    import id_exe_pipe_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    id_exe_pipe_if.slave bus
);

    logic              load_use;
    logic              insert_bubble;
    logic              bubble_ind;
    exe_payload_t      id_pl;
    exe_payload_t      exe_q;
    logic              exe_valid_q;
    logic [CTRL_W-1:0] exe_ctrl_q;
    pipe_state_e       state_q;
    pipe_state_e       state_d;

    // Flush masks the hazard so a killed instruction never counts as a load-use bubble.
    assign load_use      = bus.ID_valid_i & (bus.ID_rs1_luh_i | bus.ID_rs2_luh_i) & ~bus.flush_i;
    assign insert_bubble = bus.flush_i | load_use | ~bus.ID_valid_i;
    assign bubble_ind    = load_use & ~bus.EXE_stall_i;

    assign bus.ID_stall_o      = bus.EXE_stall_i | load_use;
    assign bus.bypass_stall_o  = bus.EXE_stall_i;
    assign bus.bypass_bubble_o = bubble_ind;

    assign id_pl = '{
        pc:       bus.ID_pc_i,
        rs1_data: bus.ID_rs1_data_i,
        rs2_data: bus.ID_rs2_data_i,
        imm:      bus.ID_imm_i,
        rd_idx:   bus.ID_rd_idx_i,
        rd_wr_en: bus.ID_rd_wr_en_i,
        mem_read: bus.ID_mem_read_i
    };

    // Bubbles clear only the side-effecting fields; the rest of the payload holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exe_valid_q <= 1'b0;
            exe_q       <= '0;
            exe_ctrl_q  <= '0;
        end else if (!bus.EXE_stall_i) begin
            if (insert_bubble) begin
                exe_valid_q    <= 1'b0;
                exe_q.rd_wr_en <= 1'b0;
                exe_q.mem_read <= 1'b0;
            end else begin
                exe_valid_q <= 1'b1;
                exe_q       <= id_pl;
                exe_ctrl_q  <= bus.ID_ctrl_i;
            end
        end
    end

    assign bus.EXE_valid_o    = exe_valid_q;
    assign bus.EXE_pc_o       = exe_q.pc;
    assign bus.EXE_rs1_data_o = exe_q.rs1_data;
    assign bus.EXE_rs2_data_o = exe_q.rs2_data;
    assign bus.EXE_imm_o      = exe_q.imm;
    assign bus.EXE_rd_idx_o   = exe_q.rd_idx;
    assign bus.EXE_rd_wr_en_o = exe_q.rd_wr_en;
    assign bus.EXE_mem_read_o = exe_q.mem_read;
    assign bus.EXE_ctrl_o     = exe_ctrl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall outranks a pending hazard; the hazard is re-evaluated once EXE frees up.
    always_comb begin
        state_d = ST_RUN;
        if (bus.EXE_stall_i) begin
            state_d = ST_HOLD;
        end else if (load_use) begin
            state_d = ST_LU;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && (state_q == ST_LU)) begin
            assert (!exe_valid_q);
        end
        if (rst_ni) begin
            assert (state_q != pipe_state_e'(2'd3));
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_bubble_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (bubble_ind),
        .cnt_o  (bus.lu_bubble_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_stall_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (bus.EXE_stall_i),
        .cnt_o  (bus.stall_cycle_cnt_o)
    );

endmodule

// File: tb/tb_id_exe_pipe.sv
// Scoreboard bench for id_exe_pipe: driver issues instructions and queues the
// expected EXE view; a monitor compares after every rising edge.
module tb_id_exe_pipe;
    import id_exe_pipe_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CTRL_W  = 16;
    localparam int unsigned CNT_MAX = 15;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    id_exe_pipe_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    id_exe_pipe #(.CNT_W(CNT_W), .CTRL_W(CTRL_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [63:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic        wr, mem;
        logic [15:0] ctrl;
    } instr_t;

    typedef struct {
        instr_t      exe;
        int unsigned lu_cnt, st_cnt;
        logic        id_stall, b_stall, b_bubble;
    } exp_t;

    instr_t      m_exe;
    int unsigned m_lu, m_st;
    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_exe = '{valid: 1'b0, pc: '0, rs1: '0, rs2: '0, imm: '0, rd: '0, wr: 1'b0, mem: 1'b0, ctrl: '0};
        m_lu  = 0;
        m_st  = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " EXE_valid"},  64'(bus.EXE_valid_o), 64'd0);
        chk({tag, " EXE_pc"},     bus.EXE_pc_o, 64'd0);
        chk({tag, " EXE_rs1"},    bus.EXE_rs1_data_o, 64'd0);
        chk({tag, " EXE_rs2"},    bus.EXE_rs2_data_o, 64'd0);
        chk({tag, " EXE_imm"},    bus.EXE_imm_o, 64'd0);
        chk({tag, " EXE_rd"},     64'(bus.EXE_rd_idx_o), 64'd0);
        chk({tag, " EXE_wr"},     64'(bus.EXE_rd_wr_en_o), 64'd0);
        chk({tag, " EXE_mem"},    64'(bus.EXE_mem_read_o), 64'd0);
        chk({tag, " EXE_ctrl"},   64'(bus.EXE_ctrl_o), 64'd0);
        chk({tag, " lu_cnt"},     64'(bus.lu_bubble_cnt_o), 64'd0);
        chk({tag, " stall_cnt"},  64'(bus.stall_cycle_cnt_o), 64'd0);
    endtask

    // One decode cycle: drive inputs at the falling edge, record what EXE must show after the next rise.
    task automatic cycle(input logic v, input logic l1, input logic l2, input logic st, input logic fl);
        instr_t id;
        exp_t   e;
        logic   hazard;
        id.valid = 1'b1;
        id.pc    = {$urandom, $urandom};
        id.rs1   = {$urandom, $urandom};
        id.rs2   = {$urandom, $urandom};
        id.imm   = {$urandom, $urandom};
        id.rd    = 5'($urandom);
        id.wr    = 1'($urandom);
        id.mem   = 1'($urandom);
        id.ctrl  = 16'($urandom);

        bus.ID_valid_i    = v;
        bus.ID_pc_i       = id.pc;
        bus.ID_rs1_data_i = id.rs1;
        bus.ID_rs2_data_i = id.rs2;
        bus.ID_imm_i      = id.imm;
        bus.ID_rd_idx_i   = id.rd;
        bus.ID_rd_wr_en_i = id.wr;
        bus.ID_mem_read_i = id.mem;
        bus.ID_ctrl_i     = id.ctrl;
        bus.ID_rs1_luh_i  = l1;
        bus.ID_rs2_luh_i  = l2;
        bus.EXE_stall_i   = st;
        bus.flush_i       = fl;

        hazard = v && (l1 || l2) && !fl;
        if (!st) begin
            if (v && !hazard && !fl) begin
                m_exe = id;
            end else begin
                m_exe.valid = 1'b0;
                m_exe.wr    = 1'b0;
                m_exe.mem   = 1'b0;
            end
        end
        if (st) m_st = (m_st < CNT_MAX) ? m_st + 1 : CNT_MAX;
        if (hazard && !st) m_lu = (m_lu < CNT_MAX) ? m_lu + 1 : CNT_MAX;

        e.exe      = m_exe;
        e.lu_cnt   = m_lu;
        e.st_cnt   = m_st;
        e.id_stall = st || hazard;
        e.b_stall  = st;
        e.b_bubble = hazard && !st;
        sb.push_back(e);
        @(negedge clk_i);
    endtask

    task automatic rand_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cycle(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 2),
                  1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 2),
                  1'($urandom_range(0, 9) < 1));
        end
    endtask

    // Asserted between edges with a valid instruction present; outputs must clear without a clock.
    task automatic async_reset();
        bus.ID_valid_i = 1'b1;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("async reset");
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("EXE_valid",  64'(bus.EXE_valid_o), 64'(mon_e.exe.valid));
                chk("EXE_pc",     bus.EXE_pc_o, mon_e.exe.pc);
                chk("EXE_rs1",    bus.EXE_rs1_data_o, mon_e.exe.rs1);
                chk("EXE_rs2",    bus.EXE_rs2_data_o, mon_e.exe.rs2);
                chk("EXE_imm",    bus.EXE_imm_o, mon_e.exe.imm);
                chk("EXE_rd",     64'(bus.EXE_rd_idx_o), 64'(mon_e.exe.rd));
                chk("EXE_wr",     64'(bus.EXE_rd_wr_en_o), 64'(mon_e.exe.wr));
                chk("EXE_mem",    64'(bus.EXE_mem_read_o), 64'(mon_e.exe.mem));
                chk("EXE_ctrl",   64'(bus.EXE_ctrl_o), 64'(mon_e.exe.ctrl));
                chk("lu_cnt",     64'(bus.lu_bubble_cnt_o), 64'(mon_e.lu_cnt));
                chk("stall_cnt",  64'(bus.stall_cycle_cnt_o), 64'(mon_e.st_cnt));
                chk("ID_stall",   64'(bus.ID_stall_o), 64'(mon_e.id_stall));
                chk("byp_stall",  64'(bus.bypass_stall_o), 64'(mon_e.b_stall));
                chk("byp_bubble", 64'(bus.bypass_bubble_o), 64'(mon_e.b_bubble));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ID_valid_i    = 1'b1;
        bus.ID_pc_i       = '0;
        bus.ID_rs1_data_i = '0;
        bus.ID_rs2_data_i = '0;
        bus.ID_imm_i      = '0;
        bus.ID_rd_idx_i   = '0;
        bus.ID_rd_wr_en_i = 1'b1;
        bus.ID_mem_read_i = 1'b0;
        bus.ID_ctrl_i     = '1;
        bus.ID_rs1_luh_i  = 1'b0;
        bus.ID_rs2_luh_i  = 1'b0;
        bus.EXE_stall_i   = 1'b0;
        bus.flush_i       = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset state");
        rst_ni = 1'b1;

        // plain flow, then a single load-use bubble followed by capture
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // stall over a pending rs2 hazard, then exactly one bubble when it drops
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // flush beats load-use; flush under stall leaves EXE untouched
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 1);
        cycle(1, 0, 0, 0, 0);
        // back-to-back hazards and an idle decode slot
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        rand_cycles(300);

        async_reset();
        cycle(1, 0, 0, 0, 0);

        // counter saturation at 4 bits
        for (int unsigned i = 0; i < 20; i++) cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 20; i++) cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);

        rand_cycles(150);

        @(negedge clk_i);
        @(negedge clk_i);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
